// File: rtl/ex_mem_pipe_reg_if.sv
// EX->MEM stage bundle: EX-side valid/ready with instruction fields,
// MEM-side valid/ready with held fields.
interface ex_mem_pipe_reg_if #(
    parameter int DATA_W     = 32,
    parameter int PC_W       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int WB_W       = 2,
    parameter int M_W        = 3
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [WB_W-1:0]       WB;
    logic [M_W-1:0]        M;
    logic [PC_W-1:0]       PC;
    logic                  zero;
    logic [DATA_W-1:0]     ALUresult;
    logic [DATA_W-1:0]     writeData;
    logic [REG_ADDR_W-1:0] writeRegister;

    logic                  out_valid;
    logic                  out_ready;
    logic [WB_W-1:0]       WB_output;
    logic [M_W-1:0]        M_output;
    logic [PC_W-1:0]       PC_output;
    logic                  zero_output;
    logic [DATA_W-1:0]     ALUresult_output;
    logic [DATA_W-1:0]     writeData_output;
    logic [REG_ADDR_W-1:0] writeRegister_output;

    // Pipeline register side: consumes EX fields, produces MEM fields.
    modport slave (
        input  in_valid, WB, M, PC, zero, ALUresult, writeData,
        input  writeRegister, out_ready,
        output in_ready, out_valid, WB_output, M_output, PC_output,
        output zero_output, ALUresult_output, writeData_output,
        output writeRegister_output
    );

    // Surrounding stages: drive EX fields, consume MEM fields.
    modport master (
        output in_valid, WB, M, PC, zero, ALUresult, writeData,
        output writeRegister, out_ready,
        input  in_ready, out_valid, WB_output, M_output, PC_output,
        input  zero_output, ALUresult_output, writeData_output,
        input  writeRegister_output
    );
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with 2-entry skid buffer, valid/ready, flush.
// Optional perf counters (stall_cnt, flush_cnt) under EX_MEM_PIPE_REG_PERF_EN.
module ex_mem_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int PC_W       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int WB_W       = 2,
    parameter int M_W        = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    ex_mem_pipe_reg_if.slave bus
`ifdef EX_MEM_PIPE_REG_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    typedef struct packed {
        logic [WB_W-1:0]       wb;
        logic [M_W-1:0]        m;
        logic [PC_W-1:0]       pc;
        logic                  zero;
        logic [DATA_W-1:0]     alu;
        logic [DATA_W-1:0]     wdata;
        logic [REG_ADDR_W-1:0] rd;
    } entry_t;

    // {skid_v, main_v}; 2'b10 is never produced.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t state, state_n;
    entry_t main_q, skid_q, in_e;
    logic   main_v, skid_v;
    logic   accept, drain;
    logic   ld_main_in, ld_main_skid, ld_skid;

    assign main_v = state[0];
    assign skid_v = state[1];

    assign in_e = '{
        wb:    bus.WB,
        m:     bus.M,
        pc:    bus.PC,
        zero:  bus.zero,
        alu:   bus.ALUresult,
        wdata: bus.writeData,
        rd:    bus.writeRegister
    };

    // in_ready depends only on registered state, never on out_ready.
    assign bus.in_ready  = !skid_v;
    assign bus.out_valid = main_v;
    assign accept        = bus.in_valid && !skid_v;
    assign drain         = main_v && bus.out_ready;

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_n;
    end

    // Next occupancy and which storage slot loads; flush beats accept/drain.
    always_comb begin
        state_n      = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            state_n = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state_n    = ONE;
                        ld_main_in = 1'b1;
                    end
                end
                ONE: begin
                    unique case (1'b1)
                        accept && drain: begin
                            state_n    = ONE;
                            ld_main_in = 1'b1;
                        end
                        accept && !drain: begin
                            state_n = FULL;
                            ld_skid = 1'b1;
                        end
                        !accept && drain: begin
                            state_n = EMPTY;
                        end
                        default: state_n = ONE;
                    endcase
                end
                FULL: begin
                    if (drain) begin
                        state_n      = ONE;
                        ld_main_skid = 1'b1;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    // Payload storage; contents persist while invalid, cleared only by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (ld_main_in)        main_q <= in_e;
            else if (ld_main_skid) main_q <= skid_q;
            if (ld_skid)           skid_q <= in_e;
        end
    end

    assign bus.WB_output            = main_v ? main_q.wb : '0;
    assign bus.M_output             = main_v ? main_q.m  : '0;
    assign bus.PC_output            = main_q.pc;
    assign bus.zero_output          = main_q.zero;
    assign bus.ALUresult_output     = main_q.alu;
    assign bus.writeData_output     = main_q.wdata;
    assign bus.writeRegister_output = main_q.rd;

`ifdef EX_MEM_PIPE_REG_PERF_EN
    // Saturating counters for stalled cycles and flushes that kill work.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (main_v && !bus.out_ready && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (flush && (main_v || skid_v) && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Bench for ex_mem_pipe_reg: directed vector table, then random traffic
// against a queue model; perf counters checked when the macro is defined.
module tb_ex_mem_pipe_reg;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    ex_mem_pipe_reg_if bus ();

`ifdef EX_MEM_PIPE_REG_PERF_EN
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;
    ex_mem_pipe_reg dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus.slave),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );
`else
    ex_mem_pipe_reg dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus.slave)
    );
`endif

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [31:0] pc;
        logic        zero;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
    } ent_t;

    typedef struct {
        logic        rst, fl, iv, ordy;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [2:0]  m;
        logic [1:0]  wb;
        logic        e_ov, e_ir;
        logic [31:0] e_alu;
        logic [4:0]  e_rd;
        logic [2:0]  e_m;
        logic [1:0]  e_wb;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    ent_t q[$];
    ent_t held;
    longint stall_m;
    int     flush_m;

    function automatic vec_t mk(
        logic r, logic f, logic iv, logic o,
        logic [31:0] a, logic [4:0] d, logic [2:0] m, logic [1:0] w,
        logic eov, logic eir, logic [31:0] ea, logic [4:0] ed,
        logic [2:0] em, logic [1:0] ew);
        vec_t v;
        v.rst = r; v.fl = f; v.iv = iv; v.ordy = o;
        v.alu = a; v.rd = d; v.m = m; v.wb = w;
        v.e_ov = eov; v.e_ir = eir; v.e_alu = ea;
        v.e_rd = ed; v.e_m = em; v.e_wb = ew;
        return v;
    endfunction

    task automatic drive(logic r, logic f, logic iv, logic o,
                         logic [31:0] a, logic [4:0] d,
                         logic [2:0] m, logic [1:0] w);
        rst               = r;
        flush             = f;
        bus.in_valid      = iv;
        bus.out_ready     = o;
        bus.ALUresult     = a;
        bus.PC            = a << 2;
        bus.writeData     = a * 32'd3;
        bus.zero          = a[0];
        bus.writeRegister = d;
        bus.M             = m;
        bus.WB            = w;
    endtask

    // Reference: a FIFO of at most two entries seen from outside.
    task automatic model_step();
        int   sz  = q.size();
        bit   acc = bus.in_valid && sz < 2;
        bit   drn = sz > 0 && bus.out_ready;
        ent_t e;
        e = '{wb: bus.WB, m: bus.M, pc: bus.PC, zero: bus.zero,
              alu: bus.ALUresult, wd: bus.writeData,
              rd: bus.writeRegister};
        if (rst) begin
            stall_m = 0;
            flush_m = 0;
        end else begin
            if (sz > 0 && !bus.out_ready && stall_m < 64'hFFFF_FFFF)
                stall_m++;
            if (flush && sz > 0 && flush_m < 16'hFFFF)
                flush_m++;
        end
        if (rst) begin
            q.delete();
            held = '0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        if (q.size() > 0) held = q[0];
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] dut_vec();
        ent_t a;
        a = '{wb: bus.WB_output, m: bus.M_output, pc: bus.PC_output,
              zero: bus.zero_output, alu: bus.ALUresult_output,
              wd: bus.writeData_output, rd: bus.writeRegister_output};
        return {19'd0, bus.out_valid, bus.in_ready, a};
    endfunction

    function automatic logic [127:0] model_vec();
        ent_t e = held;
        logic ov = q.size() > 0;
        if (!ov) begin
            e.wb = '0;
            e.m  = '0;
        end
        return {19'd0, ov, q.size() < 2, e};
    endfunction

    vec_t vecs[19];

    initial begin
        ent_t ee;
        q.delete();
        held    = '0;
        stall_m = 0;
        flush_m = 0;

        vecs[0]  = mk(1,0,1,1,'hAA,7,7,3,     0,1,0,0,0,0);
        vecs[1]  = mk(1,0,1,1,'hAA,7,7,3,     0,1,0,0,0,0);
        vecs[2]  = mk(0,0,1,1,3,3,1,1,        1,1,3,3,1,1);
        vecs[3]  = mk(0,0,1,1,4,4,1,1,        1,1,4,4,1,1);
        vecs[4]  = mk(0,0,1,1,5,5,1,1,        1,1,5,5,1,1);
        vecs[5]  = mk(0,0,0,1,0,0,1,1,        0,1,5,5,0,0);
        vecs[6]  = mk(0,0,1,0,'hA,'h1F,2,2,   1,1,'hA,'h1F,2,2);
        vecs[7]  = mk(0,0,1,0,'hB,2,2,2,      1,0,'hA,'h1F,2,2);
        vecs[8]  = mk(0,0,1,0,'hC,3,2,2,      1,0,'hA,'h1F,2,2);
        vecs[9]  = mk(0,0,1,1,'hC,3,2,2,      1,1,'hB,2,2,2);
        vecs[10] = mk(0,0,1,1,'hC,3,2,2,      1,1,'hC,3,2,2);
        vecs[11] = mk(0,0,0,1,0,0,2,2,        0,1,'hC,3,0,0);
        vecs[12] = mk(0,0,1,0,'h11,'h11,4,1,  1,1,'h11,'h11,4,1);
        vecs[13] = mk(0,0,1,0,'h12,'h12,4,1,  1,0,'h11,'h11,4,1);
        vecs[14] = mk(0,1,1,0,'h13,'h13,4,1,  0,1,'h11,'h11,0,0);
        vecs[15] = mk(0,0,0,1,0,0,4,1,        0,1,'h11,'h11,0,0);
        vecs[16] = mk(1,1,1,1,'h20,'h14,5,3,  0,1,0,0,0,0);
        vecs[17] = mk(0,0,1,0,'h4,'h15,5,3,   1,1,'h4,'h15,5,3);
        vecs[18] = mk(0,0,0,1,0,0,5,3,        0,1,'h4,'h15,0,0);

        drive(1,0,0,0,0,0,0,0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].ordy,
                  vecs[i].alu, vecs[i].rd, vecs[i].m, vecs[i].wb);
            step();
            ee = '{wb: vecs[i].e_wb, m: vecs[i].e_m,
                   pc: vecs[i].e_alu << 2, zero: vecs[i].e_alu[0],
                   alu: vecs[i].e_alu, wd: vecs[i].e_alu * 32'd3,
                   rd: vecs[i].e_rd};
            check($sformatf("vec%0d", i), dut_vec(),
                  {19'd0, vecs[i].e_ov, vecs[i].e_ir, ee});
        end

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) < 6,
                  $urandom, 5'($urandom), 3'($urandom), 2'($urandom));
            step();
            check($sformatf("rand%0d", i), dut_vec(), model_vec());
`ifdef EX_MEM_PIPE_REG_PERF_EN
            check($sformatf("rand_perf%0d", i),
                  {80'd0, flush_cnt, stall_cnt},
                  {80'd0, 16'(flush_m), 32'(stall_m)});
`endif
        end

`ifdef EX_MEM_PIPE_REG_PERF_EN
        drive(1,0,0,0,0,0,0,0);
        step();
        drive(0,0,1,0,'h77,1,1,1);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(0,0,0,0,0,0,0,0);
            step();
        end
        check("stall_cnt5", {96'd0, stall_cnt}, {96'd0, 32'd5});
        drive(0,1,0,1,0,0,0,0);
        step();
        check("flush_cnt1", {112'd0, flush_cnt}, {112'd0, 16'd1});
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
- Parametrised EX→MEM pipeline register with a valid/ready handshake and a 2-entry skid buffer.
- Carries WB/M control, PC, ALU result, store data, zero flag and destination register from the execute stage to the memory stage.
- Supports stall via backpressure and flush via a flush input.
- Control outputs are gated so the MEM stage never sees a memory op or register write from an invalid slot.

Parameters:
- DATA_W, 32, width of ALUresult and writeData.
- PC_W, 32, width of PC.
- REG_ADDR_W, 5, width of the destination register index.
- WB_W, 2, width of the WB control bundle.
- M_W, 3, width of the M control bundle.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous kill of all held entries (branch taken / exception).
- in_valid  in  1  EX stage presents a valid instruction.
- in_ready  out  1  register can accept this cycle.
- WB  in  WB_W  writeback control.
- M  in  M_W  memory control.
- PC  in  PC_W  branch target / PC.
- zero  in  1  ALU zero flag.
- ALUresult  in  DATA_W  ALU result.
- writeData  in  DATA_W  store data.
- writeRegister  in  REG_ADDR_W  destination register.
- out_valid  out  1  MEM stage slot is valid.
- out_ready  in  1  MEM stage accepts this cycle.
- WB_output  out  WB_W  gated writeback control.
- M_output  out  M_W  gated memory control.
- PC_output  out  PC_W  held PC.
- zero_output  out  1  held zero flag.
- ALUresult_output  out  DATA_W  held ALU result.
- writeData_output  out  DATA_W  held store data.
- writeRegister_output  out  REG_ADDR_W  held destination register.

Behaviour:
- Single clock domain, one clock (clk); reset is synchronous and active-high (rst). All state updates on posedge clk.
- Storage: main entry (drives outputs) plus skid entry, each with its own valid bit.
- State is encoded by {skid_v, main_v}:
  - EMPTY = 00
  - ONE = 01
  - FULL = 11
  - 10 is illegal and unreachable.
- in_ready = !skid_v, registered, with no combinational path from out_ready.
- Accept when in_valid && in_ready. Drain when out_valid && out_ready.
- Transitions:
  - EMPTY + accept → ONE; input is captured into main.
  - ONE + accept + drain → ONE; main is replaced by the input.
  - ONE + accept without drain → FULL; input is captured into skid.
  - ONE + drain without accept → EMPTY.
  - FULL + drain → ONE; skid moves to main and skid_v clears.
  - No accept is possible in FULL.
- Latency: 1 cycle from accept to out_valid when EMPTY. Full throughput of 1 per cycle when out_ready is held high.
- Ordering is strict FIFO. No entry is duplicated or dropped except by flush or rst.
- out_valid = main_v.
- WB_output and M_output are forced to 0 when main_v = 0.
- Data outputs hold their last captured value while invalid. They are not cleared except by rst.
- flush:
  - main_v and skid_v clear next edge; state goes to EMPTY.
  - An input offered in the same cycle is discarded, even if in_ready = 1.
  - in_ready = 1 the following cycle.
  - flush takes priority over accept and drain.
- rst: has priority over flush. All valids clear and all outputs go to 0 next edge (M_output = 0, WB_output = 0, data = 0). in_ready = 1 after reset.
- Reset mid-transfer: held entries are lost. This is not an error.
- Data fields are captured at full parameter widths, with no truncation or extension.

Optional Feature:
- Macro EX_MEM_PIPE_REG_PERF_EN.
- When defined, the block adds two outputs:
  - stall_cnt (32-bit): counts cycles with out_valid && !out_ready.
  - flush_cnt (16-bit): counts cycles where flush is asserted and at least one entry is valid.
- Both counters saturate at their maximum, clear on rst, and are unaffected by flush.
- When not defined, neither port nor any counter logic exists. Functional behaviour is otherwise identical.

Test Plan:
- Reset: rst=1 for 2 cycles with inputs nonzero → all outputs 0, out_valid=0, in_ready=1.
- Streaming: out_ready=1; push ALUresult 0x3, 0x4, 0x5 on consecutive cycles with M=3'b001 → outputs show 0x3, 0x4, 0x5 one cycle later each; out_valid high for 3 cycles; M_output=001 only while valid.
- Backpressure:
  - out_ready=0; push A (writeRegister=5'h1F), then B (5'h02) → FULL; in_ready=0.
  - A third push C is held off.
  - Raise out_ready → outputs A, B, C in order; no loss.
- Flush while FULL with in_valid=1 → next cycle out_valid=0, WB_output=0, M_output=0, in_ready=1; the offered entry never appears.
- Simultaneous rst and flush with in_valid=1 → reset values; next accepted entry (PC=0x10) appears alone.
- With EX_MEM_PIPE_REG_PERF_EN: hold out_ready=0 for 5 cycles with a valid entry → stall_cnt=5; a flush with valid entries → flush_cnt=1.
